deadlock_report_ctrl: RTL and testbench
=======================================

DEADLOCK_REPORT_CTRL -- requirements
Module: deadlock_report_ctrl

Interface
REQ-001 SHALL have parameter CONFIRM_CYCLES, default 16: consecutive sampled block cycles required to confirm a deadlock; legal range 2..65535.
REQ-002 SHALL have parameter NUM_CHAN, default 4: width of per-channel axis block info.
REQ-003 SHALL have parameter STAMP_W, default 32: width of cycle counter and stamp.
REQ-004 SHALL have port clock  input  1: single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port arm  input  1: detection enabled when high.
REQ-007 SHALL have port block  input  1: raw deadlock indication from the top-level deadlock monitor.
REQ-008 SHALL have port axis_block_info  input  NUM_CHAN: per-channel blocked flags from the same monitor.
REQ-009 SHALL have port clear  input  1: abandon suspicion or release halt.
REQ-010 SHALL have port report_ready  input  1: report consumer accepts.
REQ-011 SHALL have port report_valid  output  1: report payload valid.
REQ-012 SHALL have port report_info  output  NUM_CHAN: accumulated blocked-channel mask.
REQ-013 SHALL have port report_stamp  output  STAMP_W: cycle of first suspect sample (present only under macro).
REQ-014 SHALL have port suspect  output  1: high in SUSPECT state.
REQ-015 SHALL have port halt  output  1: deadlock confirmed and reported; sticky.

Function
REQ-016 SHALL implement FSM states IDLE, SUSPECT, REPORT, HALT; registered Moore outputs.
REQ-017 IDLE: arm=1 and block=1 -> SUSPECT, count<=1, mask<=axis_block_info; otherwise stay, count<=0.
REQ-018 SUSPECT: block=0 or arm=0 or clear=1 -> IDLE, count<=0, mask<=0; clear has priority over all.
REQ-019 SUSPECT: block=1 -> count<=count+1, mask<=mask OR axis_block_info; when count==CONFIRM_CYCLES-1 on that edge -> REPORT.
REQ-020 report_valid SHALL rise on the edge sampling the CONFIRM_CYCLES-th consecutive block=1 (first sample = edge leaving IDLE).
REQ-021 REPORT: report_valid=1, report_info/report_stamp held stable; report_valid AND report_ready on an edge -> HALT; block, arm, clear ignored.
REQ-022 HALT: halt=1, report_valid=0, payload held; clear=1 -> IDLE with mask cleared; otherwise stay.
REQ-023 suspect=1 only in SUSPECT; halt=1 only in HALT; report_valid=1 only in REPORT.
REQ-024 count width SHALL be 16 bits; never exceeds CONFIRM_CYCLES-1.
REQ-025 report_ready while not in REPORT SHALL have no effect.

Reset
REQ-026 reset=1 SHALL force IDLE, count=0, mask=0, stamp register=0, cycle counter=0, all outputs 0, overriding every other input incl. mid-REPORT.

Configuration
REQ-027 With DEADLOCK_CYCLE_STAMP_EN defined: free-running STAMP_W cycle counter from reset, saturating at all-ones; its value captured on IDLE->SUSPECT edge and driven on report_stamp.
REQ-028 Without DEADLOCK_CYCLE_STAMP_EN: no counter, no stamp register, report_stamp port absent; all other behaviour identical.

Structure
REQ-029 FSM state enum and width constants for count SHALL live in shared package deadlock_pkg.
REQ-030 Cycle counter SHALL be sub-module deadlock_cycle_stamp, instantiated only under the macro.

Verification (CONFIRM_CYCLES=4, NUM_CHAN=4)
REQ-031 arm=1, block=1 for 4 cycles, info 0001,0100,0001,0000 -> report_valid rises after 4th edge, report_info=0101; ready=1 next edge -> halt=1.
REQ-032 block=1 for 3 cycles then 0 -> suspect 1 for 3 cycles, back to IDLE, no report_valid.
REQ-033 report_ready held 0 for 10 cycles while block toggles -> report_valid and payload stable throughout; accepted on first ready=1.
REQ-034 HALT, clear=1 one cycle -> IDLE, halt=0; new 4-cycle block -> second report.
REQ-035 reset=1 asserted while report_valid=1 -> next edge all outputs 0, state IDLE.
REQ-036 With macro: block first sampled at cycle 100 after reset -> report_stamp=100; without macro: build succeeds, port absent.

Source files
------------

// File: rtl/deadlock_pkg.sv
// Shared types and width constants for the deadlock report controller.
package deadlock_pkg;

    localparam int unsigned COUNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_REPORT  = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

endpackage

// File: rtl/deadlock_cycle_stamp.sv
// Free-running cycle counter started at reset; saturates at all-ones.
module deadlock_cycle_stamp #(
    parameter int unsigned STAMP_W = 32
) (
    input  logic               clock,
    input  logic               reset,
    output logic [STAMP_W-1:0] value
);

    // Count every cycle, hold once all-ones is reached
    always_ff @(posedge clock) begin
        if (reset) begin
            value <= '0;
        end else if (value != {STAMP_W{1'b1}}) begin
            value <= value + STAMP_W'(1);
        end
    end

endmodule

// File: rtl/deadlock_report_ctrl.sv
// Deadlock report controller: confirms a persistent block indication,
// reports the accumulated blocked-channel mask once, then halts until cleared.
// Optional feature macro: DEADLOCK_CYCLE_STAMP_EN adds a cycle stamp of the
// first suspect sample on report_stamp.
module deadlock_report_ctrl
    import deadlock_pkg::*;
#(
    parameter int unsigned CONFIRM_CYCLES = 16,
    parameter int unsigned NUM_CHAN       = 4,
    parameter int unsigned STAMP_W        = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                arm,
    input  logic                block,
    input  logic [NUM_CHAN-1:0] axis_block_info,
    input  logic                clear,
    input  logic                report_ready,
    output logic                report_valid,
    output logic [NUM_CHAN-1:0] report_info,
`ifdef DEADLOCK_CYCLE_STAMP_EN
    output logic [STAMP_W-1:0]  report_stamp,
`endif
    output logic                suspect,
    output logic                halt
);

    localparam logic [COUNT_W-1:0] CONFIRM_LAST = COUNT_W'(CONFIRM_CYCLES - 1);

    state_t              state;
    state_t              state_next;
    logic [COUNT_W-1:0]  count;
    logic [COUNT_W-1:0]  count_next;
    logic [NUM_CHAN-1:0] mask;
    logic [NUM_CHAN-1:0] mask_next;

    // State, sample counter and accumulated mask registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            count <= '0;
            mask  <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            mask  <= mask_next;
        end
    end

    // Next-state, counter and mask update
    always_comb begin
        state_next = state;
        count_next = count;
        mask_next  = mask;
        case (state)
            ST_IDLE: begin
                if (arm && block) begin
                    state_next = ST_SUSPECT;
                    count_next = COUNT_W'(1);
                    mask_next  = axis_block_info;
                end else begin
                    count_next = '0;
                end
            end
            ST_SUSPECT: begin
                if (clear || !block || !arm) begin
                    state_next = ST_IDLE;
                    count_next = '0;
                    mask_next  = '0;
                end else begin
                    mask_next = mask | axis_block_info;
                    if (count == CONFIRM_LAST) begin
                        // Count restarts so it never exceeds CONFIRM_CYCLES-1
                        state_next = ST_REPORT;
                        count_next = '0;
                    end else begin
                        count_next = count + COUNT_W'(1);
                    end
                end
            end
            ST_REPORT: begin
                if (report_ready) begin
                    state_next = ST_HALT;
                end
            end
            ST_HALT: begin
                if (clear) begin
                    state_next = ST_IDLE;
                    mask_next  = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                count_next = '0;
                mask_next  = '0;
            end
        endcase
    end

    // Registered Moore status outputs decoded from the next state
    always_ff @(posedge clock) begin
        if (reset) begin
            suspect      <= 1'b0;
            report_valid <= 1'b0;
            halt         <= 1'b0;
        end else begin
            suspect      <= (state_next == ST_SUSPECT);
            report_valid <= (state_next == ST_REPORT);
            halt         <= (state_next == ST_HALT);
        end
    end

    assign report_info = mask;

`ifdef DEADLOCK_CYCLE_STAMP_EN
    logic [STAMP_W-1:0] cycle_value;
    logic [STAMP_W-1:0] stamp;
    logic               capture;

    deadlock_cycle_stamp #(
        .STAMP_W (STAMP_W)
    ) u_cycle_stamp (
        .clock (clock),
        .reset (reset),
        .value (cycle_value)
    );

    assign capture = (state == ST_IDLE) && (state_next == ST_SUSPECT);

    // Latch the cycle of the first suspect sample
    always_ff @(posedge clock) begin
        if (reset) begin
            stamp <= '0;
        end else if (capture) begin
            stamp <= cycle_value;
        end
    end

    assign report_stamp = stamp;
`endif

endmodule

// File: tb/tb_deadlock_report_ctrl.sv
// Self-checking bench for deadlock_report_ctrl (CONFIRM_CYCLES=4, NUM_CHAN=4)
// against a queue-based reference model; directed cases then random traffic.
module tb_deadlock_report_ctrl;

    localparam int unsigned CONF = 4;
    localparam int unsigned NCH  = 4;
    localparam int unsigned SW   = 32;

    logic           clock;
    logic           reset;
    logic           arm;
    logic           block;
    logic [NCH-1:0] info;
    logic           clear;
    logic           report_ready;
    logic           report_valid;
    logic [NCH-1:0] report_info;
    logic           suspect;
    logic           halt;
`ifdef DEADLOCK_CYCLE_STAMP_EN
    logic [SW-1:0]  report_stamp;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: list of infos seen during the current suspicion
    logic [NCH-1:0] susp_q[$];
    bit             m_reported;
    bit             m_halted;
    logic [NCH-1:0] m_info;
    int unsigned    m_cyc;
    logic [SW-1:0]  m_stamp;

    deadlock_report_ctrl #(
        .CONFIRM_CYCLES (CONF),
        .NUM_CHAN       (NCH),
        .STAMP_W        (SW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .arm             (arm),
        .block           (block),
        .axis_block_info (info),
        .clear           (clear),
        .report_ready    (report_ready),
        .report_valid    (report_valid),
        .report_info     (report_info),
`ifdef DEADLOCK_CYCLE_STAMP_EN
        .report_stamp    (report_stamp),
`endif
        .suspect         (suspect),
        .halt            (halt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one edge's worth of the behavioural rules to the model
    task automatic model_step();
        logic [NCH-1:0] acc;
        if (reset) begin
            susp_q.delete();
            m_reported = 0;
            m_halted   = 0;
            m_info     = '0;
            m_cyc      = 0;
            m_stamp    = '0;
            return;
        end
        if (m_halted) begin
            if (clear) begin
                m_halted = 0;
                m_info   = '0;
            end
        end else if (m_reported) begin
            if (report_ready) begin
                m_reported = 0;
                m_halted   = 1;
            end
        end else if (susp_q.size() == 0) begin
            if (arm && block) begin
                susp_q.push_back(info);
                m_info  = info;
                m_stamp = SW'(m_cyc);
            end
        end else begin
            if (clear || !block || !arm) begin
                susp_q.delete();
                m_info = '0;
            end else begin
                susp_q.push_back(info);
                acc = '0;
                foreach (susp_q[i]) acc |= susp_q[i];
                m_info = acc;
                if (susp_q.size() == CONF) begin
                    m_reported = 1;
                    susp_q.delete();
                end
            end
        end
        if (m_cyc != 32'hFFFF_FFFF) m_cyc++;
    endtask

    task automatic compare_all();
        check("suspect", suspect, (susp_q.size() > 0));
        check("report_valid", report_valid, m_reported);
        check("halt", halt, m_halted);
        check("report_info", report_info, m_info);
`ifdef DEADLOCK_CYCLE_STAMP_EN
        check("report_stamp", report_stamp, m_stamp);
`endif
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic set_in(input logic a, input logic b, input logic [NCH-1:0] i,
                          input logic c, input logic r);
        arm = a; block = b; info = i; clear = c; report_ready = r;
    endtask

    logic [NCH-1:0] seq31[4];
    logic [NCH-1:0] held_info;

    initial begin
        reset = 1'b1;
        set_in(0, 0, '0, 0, 0);
        tick();
        check("reset_valid", report_valid, 1'b0);
        check("reset_halt", halt, 1'b0);
        reset = 1'b0;
        tick();

        // Four blocked samples confirm; report carries OR of infos
        seq31[0] = 4'b0001; seq31[1] = 4'b0100; seq31[2] = 4'b0001; seq31[3] = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            check("pre_report_valid", report_valid, 1'b0);
            set_in(1, 1, seq31[i], 0, 0);
            tick();
        end
        check("r31_valid", report_valid, 1'b1);
        check("r31_info", report_info, 4'b0101);
        set_in(1, 1, 4'b1111, 0, 1);
        tick();
        check("r31_halt", halt, 1'b1);
        check("r31_valid_low", report_valid, 1'b0);

        // Clear releases halt, then a second report
        set_in(0, 0, '0, 1, 0);
        tick();
        check("r34_halt_low", halt, 1'b0);
        for (int i = 0; i < 4; i++) begin
            set_in(1, 1, 4'b1000, 0, 0);
            tick();
        end
        check("r34_second_report", report_valid, 1'b1);
        check("r34_info", report_info, 4'b1000);
        set_in(0, 0, '0, 0, 1);
        tick();
        set_in(0, 0, '0, 1, 0);
        tick();

        // Three blocked samples then release: no report
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 4'b0010, 0, 0);
            tick();
            check("r32_suspect", suspect, 1'b1);
        end
        set_in(1, 0, '0, 0, 0);
        tick();
        check("r32_idle", suspect, 1'b0);
        check("r32_no_report", report_valid, 1'b0);

        // Backpressure: payload stable while block/clear toggle
        for (int i = 0; i < 4; i++) begin
            set_in(1, 1, NCH'(i + 1), 0, 0);
            tick();
        end
        held_info = 4'b0111;
        for (int i = 0; i < 10; i++) begin
            set_in(i[0], ~i[0], 4'b1000, i[1], 0);
            tick();
            check("r33_valid_held", report_valid, 1'b1);
            check("r33_info_held", report_info, held_info);
        end
        set_in(0, 0, '0, 0, 1);
        tick();
        check("r33_accepted", halt, 1'b1);
        set_in(0, 0, '0, 1, 0);
        tick();

        // Reset in the middle of a pending report
        for (int i = 0; i < 4; i++) begin
            set_in(1, 1, 4'b0011, 0, 0);
            tick();
        end
        check("r35_valid_before", report_valid, 1'b1);
        reset = 1'b1;
        tick();
        check("r35_valid", report_valid, 1'b0);
        check("r35_info", report_info, 4'b0000);
        check("r35_suspect", suspect, 1'b0);
        reset = 1'b0;
        set_in(0, 0, '0, 0, 0);

`ifdef DEADLOCK_CYCLE_STAMP_EN
        // First sample 100 cycles after reset gives stamp 100
        for (int i = 0; i < 100; i++) tick();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 1, 4'b0001, 0, 0);
            tick();
        end
        check("r36_stamp", report_stamp, SW'(100));
        set_in(0, 0, '0, 0, 1);
        tick();
        set_in(0, 0, '0, 1, 0);
        tick();
`endif

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            set_in($urandom_range(0, 15) != 0,
                   $urandom_range(0, 9) < 8,
                   NCH'($urandom),
                   $urandom_range(0, 24) == 0,
                   $urandom_range(0, 2) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
